// File: rtl/rsclk02a_pkg.sv
// rsclk02a_pkg -- shared constants for the fractional baud-tick generator.
// Divisor presets assume a 50 MHz F50Clk, 16x oversampling and an 8-bit
// fractional field; divisor = 50e6 / (16 * baud) split into int + frac/256.
package rsclk02a_pkg;

  localparam int PRESET_INT_W  = 16;
  localparam int PRESET_FRAC_W = 8;

  // Reset divisor: 325 + 133/256 cycles per os_tick gives 9600 bps at 16x.
  localparam int RST_DIV_INT  = 325;
  localparam int RST_DIV_FRAC = 133;

  // Smallest integer divisor the counter can honour; smaller requests are
  // raised to this value when they are captured.
  localparam int DIV_INT_MIN = 2;

  typedef struct packed {
    logic [PRESET_INT_W-1:0]  divInt;
    logic [PRESET_FRAC_W-1:0] divFrac;
  } divPreset_t;

  typedef enum logic [3:0] {
    BAUD_2400,
    BAUD_4800,
    BAUD_9600,
    BAUD_19200,
    BAUD_38400,
    BAUD_57600,
    BAUD_115200,
    BAUD_230400,
    BAUD_460800,
    BAUD_921600,
    BAUD_6M25
  } baud_e;

  localparam divPreset_t DIV_2400   = '{divInt: 16'd1302, divFrac: 8'd21};
  localparam divPreset_t DIV_4800   = '{divInt: 16'd651,  divFrac: 8'd11};
  localparam divPreset_t DIV_9600   = '{divInt: 16'd325,  divFrac: 8'd133};
  localparam divPreset_t DIV_19200  = '{divInt: 16'd162,  divFrac: 8'd195};
  localparam divPreset_t DIV_38400  = '{divInt: 16'd81,   divFrac: 8'd97};
  localparam divPreset_t DIV_57600  = '{divInt: 16'd54,   divFrac: 8'd65};
  localparam divPreset_t DIV_115200 = '{divInt: 16'd27,   divFrac: 8'd32};
  localparam divPreset_t DIV_230400 = '{divInt: 16'd13,   divFrac: 8'd144};
  localparam divPreset_t DIV_460800 = '{divInt: 16'd6,    divFrac: 8'd200};
  localparam divPreset_t DIV_921600 = '{divInt: 16'd3,    divFrac: 8'd100};
  // 6.25 MHz oversample rate (8 cycles per os_tick). A true 6.25 Mbps bit
  // rate at 16x would need a sub-cycle divisor, below the clamp minimum.
  localparam divPreset_t DIV_6M25   = '{divInt: 16'd8,    divFrac: 8'd0};

  // Look up the divisor pair for a named rate.
  function automatic divPreset_t presetFor(input baud_e baud);
    divPreset_t p;
    p = DIV_9600;
    case (baud)
      BAUD_2400:   p = DIV_2400;
      BAUD_4800:   p = DIV_4800;
      BAUD_9600:   p = DIV_9600;
      BAUD_19200:  p = DIV_19200;
      BAUD_38400:  p = DIV_38400;
      BAUD_57600:  p = DIV_57600;
      BAUD_115200: p = DIV_115200;
      BAUD_230400: p = DIV_230400;
      BAUD_460800: p = DIV_460800;
      BAUD_921600: p = DIV_921600;
      BAUD_6M25:   p = DIV_6M25;
      default:     p = DIV_9600;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/rsclk02a_if.sv
// rsclk02a_if -- divisor configuration bus between the register block
// (master) and the baud-tick generator (slave). cfg_load is a one-cycle
// request; cfg_ack is a one-cycle pulse once the new divisor is live.
interface rsclk02a_if
  import rsclk02a_pkg::*;
#(
  parameter int INT_W  = PRESET_INT_W,
  parameter int FRAC_W = PRESET_FRAC_W
);

  logic [INT_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic              cfg_load;
  logic              cfg_ack;

  modport master (
    output cfg_div_int,
    output cfg_div_frac,
    output cfg_load,
    input  cfg_ack
  );

  modport slave (
    input  cfg_div_int,
    input  cfg_div_frac,
    input  cfg_load,
    output cfg_ack
  );

endinterface

// File: rtl/rsclk02a_frac.sv
// rsclk02a_frac -- fractional period counter. Counts divInt (+1 when the
// previous terminal carried) cycles per os period; the fractional part is
// accumulated at each terminal so that 2^FRAC_W periods span exactly
// 2^FRAC_W*divInt + divFrac cycles. term is a combinational strobe decoded
// from registered state only.
module rsclk02a_frac #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              F50Clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [INT_W-1:0]  divInt,
  input  logic [FRAC_W-1:0] divFrac,
  output logic              term
);

  localparam logic [INT_W:0] CNT_ONE = (INT_W+1)'(1);

  logic [INT_W:0]  cnt;
  logic [INT_W:0]  period;
  logic [FRAC_W-1:0] fracAcc;
  logic            carry;
  logic [FRAC_W:0] fracSum;

  // Current period length and next fractional accumulator value.
  // NOTE: every always_comb output is assigned on every path (here
  // unconditionally); a missed branch would infer a latch.
  always_comb begin
    period  = {1'b0, divInt} + {{INT_W{1'b0}}, carry};
    fracSum = {1'b0, fracAcc} + {1'b0, divFrac};
  end

  assign term = en && (cnt == period - CNT_ONE);

  // Period counter and fractional accumulator.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge F50Clk) begin
    if (reset || clear) begin
      cnt     <= '0;
      fracAcc <= '0;
      carry   <= 1'b0;
    end else if (term) begin
      cnt              <= '0;
      {carry, fracAcc} <= fracSum;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/rsclk02a.sv
// rsclk02a -- fractional baud-tick generator (os_tick / bit_tick).
// Holds the oversample phase, the divisor load/ack handshake and the
// optional gated bit clock; period counting lives in rsclk02a_frac.
// Build option: define RSCLK02A_GATED_CLK_EN to drive gatedClk from a
// cgate01a clock gate enabled by bit_tick; otherwise gatedClk is tied low.
module rsclk02a
  import rsclk02a_pkg::*;
#(
  parameter int OS_RATIO = 16,
  parameter int INT_W    = 16,
  parameter int FRAC_W   = 8
) (
  input  logic                        F50Clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        resync,
  rsclk02a_if.slave                   cfgIf,
  output logic                        os_tick,
  output logic                        bit_tick,
  output logic [$clog2(OS_RATIO)-1:0] os_phase,
  output logic                        gatedClk
);

  localparam int PH_W = $clog2(OS_RATIO);

  localparam logic [INT_W-1:0]  RST_INT  = INT_W'(RST_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV_FRAC);
  localparam logic [INT_W-1:0]  MIN_INT  = INT_W'(DIV_INT_MIN);
  localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);

  logic [INT_W-1:0]  divInt;
  logic [FRAC_W-1:0] divFrac;
  logic [INT_W-1:0]  pendInt;
  logic [FRAC_W-1:0] pendFrac;
  logic              pend;
  logic [PH_W-1:0]   phase;

  logic [INT_W-1:0]  capInt;
  logic [INT_W-1:0]  nextInt;
  logic [FRAC_W-1:0] nextFrac;
  logic              term;
  logic              bitTerm;
  logic              apply;
  logic              fracClear;

  // Clamp, pending-value selection and apply decision. A load arriving in
  // the same cycle as an apply opportunity is applied directly (last wins).
  always_comb begin
    capInt    = (cfgIf.cfg_div_int < MIN_INT) ? MIN_INT : cfgIf.cfg_div_int;
    nextInt   = cfgIf.cfg_load ? capInt : pendInt;
    nextFrac  = cfgIf.cfg_load ? cfgIf.cfg_div_frac : pendFrac;
    bitTerm   = term && (&phase);
    apply     = (pend || cfgIf.cfg_load) && (bitTerm || !en || resync);
    fracClear = !en || resync || apply;
  end

  rsclk02a_frac #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) uFrac (
    .F50Clk  (F50Clk),
    .reset   (reset),
    .en      (en),
    .clear   (fracClear),
    .divInt  (divInt),
    .divFrac (divFrac),
    .term    (term)
  );

  // Registered tick outputs and the oversample phase; resync swallows a
  // terminal falling in its own cycle.
  always_ff @(posedge F50Clk) begin
    if (reset) begin
      os_tick       <= 1'b0;
      bit_tick      <= 1'b0;
      cfgIf.cfg_ack <= 1'b0;
      phase         <= '0;
    end else begin
      os_tick       <= term && !resync;
      bit_tick      <= bitTerm && !resync;
      cfgIf.cfg_ack <= apply;
      if (!en || resync) begin
        phase <= '0;
      end else if (term) begin
        phase <= phase + PH_ONE;
      end
    end
  end

  // Divisor capture into the pending slot and transfer to the live divisor.
  always_ff @(posedge F50Clk) begin
    if (reset) begin
      divInt   <= RST_INT;
      divFrac  <= RST_FRAC;
      pendInt  <= RST_INT;
      pendFrac <= RST_FRAC;
      pend     <= 1'b0;
    end else if (apply) begin
      divInt  <= nextInt;
      divFrac <= nextFrac;
      pend    <= 1'b0;
    end else if (cfgIf.cfg_load) begin
      pendInt  <= capInt;
      pendFrac <= cfgIf.cfg_div_frac;
      pend     <= 1'b1;
    end
  end

  assign os_phase = phase;

`ifdef RSCLK02A_GATED_CLK_EN
  cgate01a uGate (
    .clk  (F50Clk),
    .en   (bit_tick),
    .test (1'b0),
    .gclk (gatedClk)
  );
`else
  assign gatedClk = 1'b0;
`endif

endmodule

// File: tb/tb_rsclk02a.sv
// tb_rsclk02a -- scoreboard bench for rsclk02a. Expected tick arrival
// times, bit flags and phases are computed from the divisor arithmetic when
// stimulus is applied, then popped as the DUT raises os_tick.
module tb_rsclk02a;

  localparam int OS_RATIO = 16;
  localparam int INT_W    = 16;
  localparam int FRAC_W   = 8;

  logic       F50Clk = 1'b0;
  logic       reset;
  logic       en;
  logic       resync;
  logic       os_tick;
  logic       bit_tick;
  logic [3:0] os_phase;
  logic       gatedClk;

  rsclk02a_if #(.INT_W(INT_W), .FRAC_W(FRAC_W)) cfgIf ();

  rsclk02a #(
    .OS_RATIO (OS_RATIO),
    .INT_W    (INT_W),
    .FRAC_W   (FRAC_W)
  ) dut (
    .F50Clk   (F50Clk),
    .reset    (reset),
    .en       (en),
    .resync   (resync),
    .cfgIf    (cfgIf),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .os_phase (os_phase),
    .gatedClk (gatedClk)
  );

  always #10 F50Clk = ~F50Clk;

  typedef struct {
    int         t;
    bit         bitT;
    logic [3:0] ph;
  } tickExp_t;

  tickExp_t sbQ[$];
  int now   = 0;
  int total = 0;
  int bad   = 0;

  // One clock; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge F50Clk);
    now++;
  endtask

  // Expected ticks for a fresh start: counting begins in the cycle whose
  // inputs are set at negedge t0, phase and accumulator start at 0.
  task automatic push_ticks(input int t0, input int dInt, input int dFrac, input int n);
    int t;
    int acc;
    int cy;
    int ph;
    tickExp_t e;
    t = t0; acc = 0; cy = 0; ph = 0;
    for (int i = 0; i < n; i++) begin
      t  = t + dInt + cy;
      ph = (ph + 1) % OS_RATIO;
      e.t = t; e.bitT = (ph == 0); e.ph = 4'(ph);
      sbQ.push_back(e);
      acc = acc + dFrac;
      cy  = acc >> FRAC_W;
      acc = acc % (1 << FRAC_W);
    end
  endtask

  // Drain the scoreboard: every os_tick must match the next expected entry.
  task automatic run_sb(input string name, input int budget, output int tFirst, output int tLast);
    int left;
    bit first;
    tickExp_t e;
    left = budget; first = 1'b1; tFirst = 0; tLast = 0;
    while (sbQ.size() > 0) begin
      if (left == 0) begin
        total++; bad++;
        $display("FAIL %s: timeout with %0d ticks outstanding, required 0", name, sbQ.size());
        sbQ.delete();
        break;
      end
      step(); left--;
      if (os_tick === 1'b1) begin
        e = sbQ.pop_front();
        total++;
        if (now !== e.t || bit_tick !== e.bitT || os_phase !== e.ph) begin
          bad++;
          $display("FAIL %s: tick at %0d bit=%b phase=%0d, required at %0d bit=%b phase=%0d",
                   name, now, bit_tick, os_phase, e.t, e.bitT, e.ph);
        end
        if (first) tFirst = now;
        first = 1'b0;
        tLast = now;
      end else if (bit_tick !== 1'b0) begin
        total++; bad++;
        $display("FAIL %s: bit_tick=%b without os_tick at %0d, required 0", name, bit_tick, now);
      end
    end
  endtask

  // After a running load: exactly one ack, in the same cycle as the next
  // bit_tick (one cycle after the bit-boundary terminal).
  task automatic wait_apply(input string name, input int acksIn, input int budget);
    int acks;
    int ackT;
    int bitT;
    int left;
    acks = acksIn; ackT = -1; bitT = -1; left = budget;
    while (left > 0) begin
      if (cfgIf.cfg_ack === 1'b1) begin acks++; ackT = now; end
      if (bit_tick === 1'b1) begin bitT = now; break; end
      step(); left--;
    end
    total++;
    if (bitT < 0) begin
      bad++;
      $display("FAIL %s_boundary: no bit_tick within %0d cycles, required one", name, budget);
    end
    total++;
    if (acks !== 1 || ackT !== bitT) begin
      bad++;
      $display("FAIL %s_ack: acks=%0d at %0d, required 1 at %0d", name, acks, ackT, bitT);
    end
  endtask

  task automatic pulse_load(input int dInt, input int dFrac);
    cfgIf.cfg_div_int  = INT_W'(dInt);
    cfgIf.cfg_div_frac = FRAC_W'(dFrac);
    cfgIf.cfg_load     = 1'b1;
    step();
    cfgIf.cfg_load     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; resync = 1'b0;
    cfgIf.cfg_load = 1'b0; cfgIf.cfg_div_int = '0; cfgIf.cfg_div_frac = '0;
    repeat (3) step();
    total++;
    if ({os_tick, bit_tick, cfgIf.cfg_ack, gatedClk} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: os=%b bit=%b ack=%b gclk=%b, required all 0",
               os_tick, bit_tick, cfgIf.cfg_ack, gatedClk);
    end
    total++;
    if (os_phase !== 4'd0) begin
      bad++;
      $display("FAIL reset_phase: os_phase=%0d, required 0", os_phase);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_default();
    int tf, tl;
    en = 1'b1;
    push_ticks(now, 325, 133, 48);
    run_sb("default_9600", 17000, tf, tl);
    en = 1'b0;
    step(); step();
    total++;
    if (os_tick !== 1'b0 || os_phase !== 4'd0) begin
      bad++;
      $display("FAIL en_low_idle: os_tick=%b os_phase=%0d, required 0 and 0", os_tick, os_phase);
    end
  endtask

  task automatic test_frac_span();
    int tf, tl;
    pulse_load(2, 133);
    total++;
    if (cfgIf.cfg_ack !== 1'b1) begin
      bad++;
      $display("FAIL idle_load_ack: cfg_ack=%b, required 1", cfgIf.cfg_ack);
    end
    step();
    total++;
    if (cfgIf.cfg_ack !== 1'b0) begin
      bad++;
      $display("FAIL idle_ack_single: cfg_ack=%b, required 0", cfgIf.cfg_ack);
    end
    en = 1'b1;
    push_ticks(now, 2, 133, 257);
    run_sb("frac_2_133", 1000, tf, tl);
    total++;
    if (tl - tf !== 2 * 256 + 133) begin
      bad++;
      $display("FAIL frac_span_256: span=%0d, required %0d", tl - tf, 2 * 256 + 133);
    end
  endtask

  task automatic test_cfg_running();
    int tf, tl;
    pulse_load(8, 0);
    wait_apply("load8_running", 0, 200);
    push_ticks(now, 8, 0, 32);
    run_sb("spacing_8", 400, tf, tl);
  endtask

  task automatic test_back_to_back();
    int tf, tl;
    int pre;
    pre = 0;
    cfgIf.cfg_div_int = 16'd10; cfgIf.cfg_div_frac = '0; cfgIf.cfg_load = 1'b1;
    step();
    if (cfgIf.cfg_ack === 1'b1) pre++;
    cfgIf.cfg_div_int = 16'd20;
    step();
    cfgIf.cfg_load = 1'b0;
    wait_apply("double_load", pre, 300);
    push_ticks(now, 20, 0, 16);
    run_sb("spacing_20", 400, tf, tl);
  endtask

  task automatic test_resync();
    int tf, tl;
    pulse_load(8, 0);
    wait_apply("load8_for_resync", 0, 400);
    step(); step(); step();
    resync = 1'b1;
    push_ticks(now + 1, 8, 0, 3);
    step();
    resync = 1'b0;
    total++;
    if (os_tick !== 1'b0) begin
      bad++;
      $display("FAIL resync_mid_no_tick: os_tick=%b, required 0", os_tick);
    end
    run_sb("resync_mid", 60, tf, tl);
    repeat (7) step();
    resync = 1'b1;
    push_ticks(now + 1, 8, 0, 3);
    step();
    resync = 1'b0;
    total++;
    if (os_tick !== 1'b0) begin
      bad++;
      $display("FAIL resync_on_term: os_tick=%b, required 0 (suppressed)", os_tick);
    end
    run_sb("resync_term", 60, tf, tl);
  endtask

  task automatic test_clamp();
    int tf, tl;
    en = 1'b0;
    step(); step();
    pulse_load(1, 0);
    total++;
    if (cfgIf.cfg_ack !== 1'b1) begin
      bad++;
      $display("FAIL clamp_ack: cfg_ack=%b, required 1", cfgIf.cfg_ack);
    end
    en = 1'b1;
    push_ticks(now, 2, 0, 8);
    run_sb("clamp_2", 40, tf, tl);
  endtask

  task automatic test_reset_mid();
    int tf, tl;
    reset = 1'b1;
    step();
    total++;
    if ({os_tick, bit_tick, cfgIf.cfg_ack} !== 3'b000 || os_phase !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_drop: os=%b bit=%b ack=%b phase=%0d, required 0",
               os_tick, bit_tick, cfgIf.cfg_ack, os_phase);
    end
    step();
    total++;
    if (os_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_hold: os_tick=%b, required 0", os_tick);
    end
    reset = 1'b0;
    push_ticks(now, 325, 133, 3);
    run_sb("reset_divisor", 1200, tf, tl);
  endtask

  initial begin
    test_reset();
    test_default();
    test_frac_span();
    test_cfg_running();
    test_back_to_back();
    test_resync();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
